// File: rtl/buff_uart_ctrl.sv
// rtl/buff_uart_ctrl.sv - register-mapped UART with RX/TX FIFOs and irq; optional parity via BUFF_UART_PARITY_EN

module buff_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;
    logic             pop;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign m_tvalid = (wr_ptr != rd_ptr);
    assign m_tdata  = mem[rd_ptr[AW-1:0]];
    // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
    assign s_tready = !full || m_tready;
    assign pop      = m_tvalid && m_tready;
    assign push     = s_tvalid && s_tready;

    // Read/write pointers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, contents are don't-care until written
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_tdata;
    end
endmodule

module buff_uart_ctrl #(
    parameter int width           = 8,
    parameter int data_bits       = 8,
    parameter int rx_fifo_length  = 16,
    parameter int tx_fifo_length  = 16,
    parameter int address_width   = 4,
    parameter int rx_address      = 0,
    parameter int tx_address      = 1,
    parameter int status_address  = 2,
    parameter int control_address = 3,
    parameter int baud_rate       = 9600,
    parameter int clock_freq      = 460800,
    parameter int oversample      = 16
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     rx,
    output logic                     tx,
    input  logic                     read_enable,
    input  logic                     write_enable,
    input  logic [address_width-1:0] active_address,
    input  logic [width-1:0]         data_in,
    output logic [width-1:0]         data_out,
    output logic                     recieved_byte,
    output logic                     transmitted_byte,
    output logic                     irq
);
    localparam int DIV  = clock_freq / (baud_rate * oversample);
    localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OSW  = (oversample > 1) ? $clog2(oversample) : 1;
    localparam int BW   = $clog2(data_bits);
    localparam logic [OSW-1:0] OS_LAST = OSW'(oversample - 1);
    localparam logic [OSW-1:0] OS_HALF = OSW'(oversample / 2 - 1);
    localparam logic [BW-1:0]  DB_LAST = BW'(data_bits - 1);
    localparam logic [address_width-1:0] A_RX = address_width'(rx_address);
    localparam logic [address_width-1:0] A_TX = address_width'(tx_address);
    localparam logic [address_width-1:0] A_ST = address_width'(status_address);
    localparam logic [address_width-1:0] A_CT = address_width'(control_address);
    localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
                           S_PARITY = 3'd3, S_STOP = 3'd4, S_WAIT = 3'd5;
`ifdef BUFF_UART_PARITY_EN
    localparam logic       HAS_PARITY = 1'b1;
    localparam logic [4:0] CTRL_MASK  = 5'h1f;
`else
    localparam logic       HAS_PARITY = 1'b0;
    localparam logic [4:0] CTRL_MASK  = 5'h07;
`endif

    if (DIV < 1) begin : g_bad_divisor
        $error("buff_uart_ctrl: clock_freq/(baud_rate*oversample) must be >= 1");
    end

    logic [4:0]           ctrl;
    logic                 overrun, frame_err, parity_err;
    logic [DIVW-1:0]      div_cnt;
    logic                 tick;
    logic                 wr_tx, wr_st, wr_ct, rd_any, rd_rx;
    logic [data_bits-1:0] rx_head, tx_head, rx_shift, tx_shift;
    logic                 rx_valid, rx_full, rx_in_ready, tx_valid, tx_full, tx_in_ready;
    logic                 rx_store, frame_set, tx_pop, tx_busy;
    logic [7:0]           status;
    logic [2:0]           rx_state, tx_state;
    logic [OSW-1:0]       rx_os, tx_os;
    logic [BW-1:0]        rx_bit, tx_bit;
    logic                 rx_s1, rx_s2, rx_prev, rx_par_en, rx_par_odd, rx_par_bad;
    logic                 tx_stop2, tx_par_en, tx_par_bit;

    assign wr_tx  = write_enable && (active_address == A_TX);
    assign wr_st  = write_enable && (active_address == A_ST);
    assign wr_ct  = write_enable && (active_address == A_CT);
    assign rd_any = read_enable && !write_enable;
    assign rd_rx  = rd_any && (active_address == A_RX);
    assign tick   = (div_cnt == DIVW'(DIV - 1));
    assign tx_busy = (tx_state != S_IDLE);
    assign status = {tx_busy, parity_err, frame_err, overrun, tx_full, !tx_valid, rx_full, rx_valid};
    assign rx_store  = (rx_state == S_STOP) && tick && (rx_os == OS_LAST) && rx_s2;
    assign frame_set = (rx_state == S_STOP) && tick && (rx_os == OS_LAST) && !rx_s2;
    assign tx_pop = tick && tx_valid &&
                    ((tx_state == S_IDLE) || ((tx_state == S_STOP) && (tx_os == OS_LAST) && !tx_stop2));

    buff_uart_fifo #(.WIDTH(data_bits), .DEPTH(rx_fifo_length)) u_rx_fifo (
        .clock(clock), .resetn(resetn),
        .s_tdata(rx_shift), .s_tvalid(rx_store), .s_tready(rx_in_ready),
        .m_tdata(rx_head), .m_tvalid(rx_valid), .m_tready(rd_rx), .full(rx_full)
    );

    buff_uart_fifo #(.WIDTH(data_bits), .DEPTH(tx_fifo_length)) u_tx_fifo (
        .clock(clock), .resetn(resetn),
        .s_tdata(data_in[data_bits-1:0]), .s_tvalid(wr_tx && tx_in_ready), .s_tready(tx_in_ready),
        .m_tdata(tx_head), .m_tvalid(tx_valid), .m_tready(tx_pop), .full(tx_full)
    );

    // Free-running baud divisor producing one-cycle oversample ticks
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) div_cnt <= '0;
        else         div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    // Control register, sticky flags (set wins over W1C), registered read data and irq
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ctrl       <= '0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            data_out   <= '0;
            irq        <= 1'b0;
        end else begin
            if (wr_ct) ctrl <= data_in[4:0] & CTRL_MASK;
            overrun    <= (rx_store && !rx_in_ready) || (overrun && !(wr_st && data_in[4]));
            frame_err  <= frame_set || (frame_err && !(wr_st && data_in[5]));
            parity_err <= (rx_store && rx_par_bad) || (parity_err && !(wr_st && data_in[6]));
            if (rd_any) begin
                case (active_address)
                    A_RX:    data_out <= rx_valid ? width'(rx_head) : '0;
                    A_ST:    data_out <= width'(status);
                    A_CT:    data_out <= width'(ctrl);
                    default: data_out <= '0;
                endcase
            end
            irq <= (ctrl[1] && rx_valid) || (ctrl[2] && !tx_valid && !tx_busy);
        end
    end

    // Receiver: synchroniser, start qualification, mid-bit sampling, stop/parity checks
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
            rx_state <= S_IDLE; rx_os <= '0; rx_bit <= '0; rx_shift <= '0;
            rx_par_en <= 1'b0; rx_par_odd <= 1'b0; rx_par_bad <= 1'b0;
            recieved_byte <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            recieved_byte <= rx_store && rx_in_ready;
            case (rx_state)
                S_IDLE: if (rx_prev && !rx_s2) begin
                    rx_state   <= S_START;
                    rx_os      <= '0;
                    rx_par_en  <= ctrl[3];
                    rx_par_odd <= ctrl[4];
                    rx_par_bad <= 1'b0;
                end
                S_START: if (tick) begin
                    if (rx_os == OS_HALF) begin
                        rx_os    <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        rx_os <= rx_os + 1'b1;
                    end
                end
                S_WAIT: if (rx_s2) rx_state <= S_IDLE;
                default: if (tick) begin
                    rx_os <= (rx_os == OS_LAST) ? '0 : rx_os + 1'b1;
                    if (rx_os == OS_LAST) begin
                        case (rx_state)
                            S_DATA: begin
                                rx_shift <= {rx_s2, rx_shift[data_bits-1:1]};
                                rx_bit   <= rx_bit + 1'b1;
                                if (rx_bit == DB_LAST)
                                    rx_state <= (HAS_PARITY && rx_par_en) ? S_PARITY : S_STOP;
                            end
                            S_PARITY: begin
                                rx_par_bad <= rx_s2 ^ (^rx_shift) ^ rx_par_odd;
                                rx_state   <= S_STOP;
                            end
                            default: rx_state <= rx_s2 ? S_IDLE : S_WAIT;
                        endcase
                    end
                end
            endcase
        end
    end

    // Transmitter: frame format latched at pop, next frame starts straight out of STOP
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tx <= 1'b1; tx_state <= S_IDLE; tx_os <= '0; tx_bit <= '0; tx_shift <= '0;
            tx_stop2 <= 1'b0; tx_par_en <= 1'b0; tx_par_bit <= 1'b0;
            transmitted_byte <= 1'b0;
        end else begin
            transmitted_byte <= 1'b0;
            if (tx_pop) begin
                transmitted_byte <= (tx_state == S_STOP);
                tx_state   <= S_START;
                tx         <= 1'b0;
                tx_os      <= '0;
                tx_shift   <= tx_head;
                tx_stop2   <= ctrl[0];
                tx_par_en  <= ctrl[3];
                tx_par_bit <= (^tx_head) ^ ctrl[4];
            end else if (tick && tx_busy) begin
                tx_os <= (tx_os == OS_LAST) ? '0 : tx_os + 1'b1;
                if (tx_os == OS_LAST) begin
                    case (tx_state)
                        S_START: begin
                            tx_state <= S_DATA;
                            tx       <= tx_shift[0];
                            tx_bit   <= '0;
                        end
                        S_DATA: if (tx_bit == DB_LAST) begin
                            tx_state <= (HAS_PARITY && tx_par_en) ? S_PARITY : S_STOP;
                            tx       <= (HAS_PARITY && tx_par_en) ? tx_par_bit : 1'b1;
                        end else begin
                            tx_shift <= tx_shift >> 1;
                            tx       <= tx_shift[1];
                            tx_bit   <= tx_bit + 1'b1;
                        end
                        S_PARITY: begin
                            tx_state <= S_STOP;
                            tx       <= 1'b1;
                        end
                        default: if (tx_stop2) begin
                            tx_stop2 <= 1'b0;
                        end else begin
                            tx_state         <= S_IDLE;
                            transmitted_byte <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_buff_uart_ctrl.sv
// tb/tb_buff_uart_ctrl.sv - scoreboard bench for buff_uart_ctrl; define BUFF_UART_PARITY_EN to cover parity

module tb_buff_uart_ctrl;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       rx = 1'b1;
    logic       read_enable = 1'b0;
    logic       write_enable = 1'b0;
    logic [3:0] active_address = '0;
    logic [7:0] data_in = '0;
    logic       tx;
    logic [7:0] data_out;
    logic       recieved_byte, transmitted_byte, irq;

    int         n_tests = 0;
    int         n_fail = 0;
    int         rb_cnt = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    always #5 clock = ~clock;

    buff_uart_ctrl dut (
        .clock(clock), .resetn(resetn), .rx(rx), .tx(tx),
        .read_enable(read_enable), .write_enable(write_enable),
        .active_address(active_address), .data_in(data_in), .data_out(data_out),
        .recieved_byte(recieved_byte), .transmitted_byte(transmitted_byte), .irq(irq)
    );

    always @(negedge clock) if (recieved_byte) rb_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clock);
        write_enable = 1'b1; active_address = a; data_in = d;
        @(negedge clock);
        write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clock);
        read_enable = 1'b1; active_address = a;
        @(negedge clock);
        read_enable = 1'b0;
        d = data_out;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic tx_send(input logic [7:0] d);
        bus_write(4'd1, d);
        tx_q.push_back(d);
    endtask

    task automatic rx_pop_check(input string tag);
        logic [7:0] d, e;
        bus_read(4'd0, d);
        check({tag, "_sb"}, rx_q.size() != 0, 1);
        if (rx_q.size() != 0) begin
            e = rx_q.pop_front();
            check(tag, d, e);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_v, input bit with_par, input logic par_v);
        @(negedge clock);
        rx = 1'b0;
        repeat (48) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (48) @(negedge clock);
        end
        if (with_par) begin
            rx = par_v;
            repeat (48) @(negedge clock);
        end
        rx = stop_v;
        repeat (48) @(negedge clock);
        rx = 1'b1;
        repeat (12) @(negedge clock);
    endtask

    // Waits for a start bit, samples each bit mid-way, and times the done pulse from the start edge.
    task automatic tx_capture(input string tag, input int extra, output logic [11:0] bits, output int waited);
        int pulse_at;
        logic [7:0] e;
        bits = '1;
        pulse_at = -1;
        waited = 0;
        while (tx !== 1'b0 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        check({tag, "_start_seen"}, waited < 200, 1);
        if (waited >= 200) return;
        for (int i = 1; i <= 700 && pulse_at < 0; i++) begin
            @(negedge clock);
            if (i % 48 == 24 && (i - 24) / 48 <= 9 + extra) bits[(i - 24) / 48] = tx;
            if (transmitted_byte) pulse_at = i;
        end
        check({tag, "_pulse_at"}, pulse_at, 480 + 48 * extra);
        check({tag, "_start_bit"}, bits[0], 0);
        check({tag, "_stop_bit"}, bits[9 + extra], 1);
        check({tag, "_sb"}, tx_q.size() != 0, 1);
        if (tx_q.size() != 0) begin
            e = tx_q.pop_front();
            check({tag, "_data"}, bits[8:1], e);
        end
    endtask

    initial begin
        logic [11:0] bits;
        int          waited;
        int          rb0;
        logic [7:0]  v;

        repeat (3) @(negedge clock);
        check("rst_tx", tx, 1);
        check("rst_data_out", data_out, 0);
        check("rst_irq", irq, 0);
        check("rst_rx_pulse", recieved_byte, 0);
        check("rst_tx_pulse", transmitted_byte, 0);
        resetn = 1'b1;
        @(negedge clock);
        read_check("rst_status", 4'd2, 8'h04);
        read_check("rst_control", 4'd3, 8'h00);
        read_check("unmapped", 4'd9, 8'h00);
        read_check("rx_empty_read", 4'd0, 8'h00);
        read_check("rx_empty_no_flag", 4'd2, 8'h04);

        tx_send(8'h55);
        tx_capture("tx55", 0, bits, waited);
        read_check("tx55_status", 4'd2, 8'h04);

        tx_send(8'h3C);
        tx_send(8'hC3);
        tx_capture("b2b_a", 0, bits, waited);
        tx_capture("b2b_b", 0, bits, waited);
        check("b2b_gap", waited, 0);

        bus_write(4'd3, 8'h01);
        tx_send(8'hA6);
        tx_capture("two_stop", 1, bits, waited);
        check("two_stop_first", bits[9], 1);
        bus_write(4'd3, 8'h00);

        bus_write(4'd3, 8'h02);
        rb0 = rb_cnt;
        rx_q.push_back(8'hA3);
        send_rx(8'hA3, 1'b1, 1'b0, 1'b0);
        check("rxA3_pulse", rb_cnt - rb0, 1);
        read_check("rxA3_status", 4'd2, 8'h05);
        check("rxA3_irq", irq, 1);
        rx_pop_check("rxA3_data");
        repeat (2) @(negedge clock);
        check("rx_irq_clear", irq, 0);
        read_check("rxA3_status_after", 4'd2, 8'h04);
        bus_write(4'd3, 8'h04);
        repeat (2) @(negedge clock);
        check("tx_irq", irq, 1);
        bus_write(4'd3, 8'h00);

        rb0 = rb_cnt;
        for (int i = 0; i < 17; i++) begin
            v = 8'(i * 37 + 5);
            if (i < 16) rx_q.push_back(v);
            send_rx(v, 1'b1, 1'b0, 1'b0);
        end
        check("ovr_pulses", rb_cnt - rb0, 16);
        read_check("ovr_status", 4'd2, 8'h17);
        for (int i = 0; i < 16; i++) rx_pop_check("ovr_data");
        read_check("ovr_sticky", 4'd2, 8'h14);
        bus_write(4'd2, 8'h10);
        read_check("ovr_cleared", 4'd2, 8'h04);

        rb0 = rb_cnt;
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clock);
        check("ferr_no_store", rb_cnt - rb0, 0);
        read_check("ferr_status", 4'd2, 8'h24);
        bus_write(4'd2, 8'h20);
        read_check("ferr_cleared", 4'd2, 8'h04);

        @(negedge clock);
        rx = 1'b0;
        @(negedge clock);
        rx = 1'b1;
        repeat (100) @(negedge clock);
        check("glitch_no_store", rb_cnt - rb0, 0);
        read_check("glitch_status", 4'd2, 8'h04);

`ifdef BUFF_UART_PARITY_EN
        bus_write(4'd3, 8'h18);
        read_check("par_control", 4'd3, 8'h18);
        tx_send(8'h01);
        tx_capture("par_tx", 1, bits, waited);
        check("par_tx_bit", bits[9], 0);
        rb0 = rb_cnt;
        rx_q.push_back(8'h01);
        send_rx(8'h01, 1'b1, 1'b1, 1'b1);
        check("par_rx_pulse", rb_cnt - rb0, 1);
        read_check("par_status", 4'd2, 8'h45);
        rx_pop_check("par_rx_data");
        bus_write(4'd2, 8'h40);
        read_check("par_cleared", 4'd2, 8'h04);
`else
        bus_write(4'd3, 8'h1F);
        read_check("ctrl_mask", 4'd3, 8'h07);
        bus_write(4'd3, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/buff_uart_ctrl.md
Name: buff_uart_ctrl

Overview:
Parametrised successor to the single buffered UART. Register-mapped UART core with separate RX/TX FIFOs of independent depth and a configurable frame (data bits, one or two stop bits). Adds a control register, sticky error status with write-1-to-clear, 16x oversampled RX and a level interrupt. Sits on the same simple read/write address bus as the existing UART peripherals.

Parameters:
width, 8, bus data width for data_in/data_out; must be >= 8
data_bits, 8, UART frame data bits, 5..width
rx_fifo_length, 16, RX FIFO depth, power of two >= 2
tx_fifo_length, 16, TX FIFO depth, power of two >= 2
address_width, 4, width of active_address
rx_address, 0, RX data register (read pops)
tx_address, 1, TX data register (write pushes)
status_address, 2, status register (read; write-1-to-clear)
control_address, 3, control register (read/write)
baud_rate, 9600, line rate in bits/s
clock_freq, 460800, clock frequency in Hz
oversample, 16, RX samples per bit; tick divisor = clock_freq/(baud_rate*oversample), elaboration error if < 1

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
rx  input  1  serial input, asynchronous, 2-flop synchronised
tx  output  1  serial output, idle high
read_enable  input  1  bus read strobe, one access per cycle
write_enable  input  1  bus write strobe
active_address  input  address_width  register select
data_in  input  width  write data
data_out  output  width  read data, registered
recieved_byte  output  1  1-cycle pulse when a frame is stored in RX FIFO
transmitted_byte  output  1  1-cycle pulse when a TX stop bit completes
irq  output  1  level interrupt

Behaviour:
- Reset: tx=1, data_out=0, recieved_byte=0, transmitted_byte=0, irq=0, both FIFOs empty, control=0, sticky flags=0, both FSMs IDLE, tick counter 0.
- Bus: data_out valid the cycle after read_enable (1-cycle latency) and holds until the next read. Read of an unmapped address returns 0. write_enable and read_enable in the same cycle: write executes, read ignored, data_out unchanged.
- RX read: returns zero-extended FIFO head and pops. Empty RX FIFO: returns 0, no pop, no flag.
- TX write: pushes data_in[data_bits-1:0]. Full TX FIFO: write dropped silently.
- Control bits: [0] two_stop; [1] rx_irq_en; [2] tx_irq_en; [3] parity_en; [4] parity_odd. Upper bits read 0. Changes take effect at the next frame start; an in-flight frame is unaffected.
- Status bits: [0] rx_not_empty; [1] rx_full; [2] tx_empty; [3] tx_full; [4] overrun (sticky); [5] frame_error (sticky); [6] parity_error (sticky); [7] tx_busy. Writing 1 to bits 4..6 clears them. A same-cycle set wins over clear.
- Tick: free-running divisor counter produces a 1-cycle tick. One bit time = oversample ticks. Defaults give 3 clocks/tick and 48 clocks/bit.
- TX FSM: IDLE -> START -> DATA (LSB first, data_bits) -> [PARITY] -> STOP (1 or 2 bits) -> IDLE.
  - Leaves IDLE on the first tick with the TX FIFO non-empty; pops on entry to START.
  - transmitted_byte pulses on the last tick of STOP. Back-to-back frames run with no idle gap.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE leaves on the synchronised falling edge. START is re-sampled at oversample/2 ticks; if high, it is a false start and returns to IDLE.
  - Data is sampled mid-bit. One stop bit is checked regardless of two_stop.
  - Stop=0: frame discarded, frame_error set, FSM waits for rx high before IDLE.
  - Parity mismatch: frame stored, parity_error set.
  - RX FIFO full at store: frame dropped, overrun set, no recieved_byte pulse.
  - Simultaneous store and pop on a full FIFO: pop first, then store; no overrun.
- irq = (rx_irq_en & rx_not_empty) | (tx_irq_en & tx_empty & !tx_busy), registered, one-cycle lag.
- Reset asserted mid-frame: everything returns to reset values immediately; tx goes high.

Optional Feature:
BUFF_UART_PARITY_EN: when defined, parity generation/check and control bits [4:3] exist, status[6] is live, and the PARITY state is used when parity_en=1 (even when parity_odd=0). When undefined: no PARITY state, control[4:3] and status[6] read 0, writes to them are ignored.

Test Plan:
- Reset, then read status -> 0x04 (tx_empty only); tx=1; data_out=0.
- Write 0x55 to tx_address, defaults -> tx low for 48 clocks, then bits 1,0,1,0,1,0,1,0 at 48 clocks each, stop high; transmitted_byte pulses 480 clocks after start; status returns to 0x04.
- Drive rx frame 0xA3 (8N1, 48 clocks/bit) -> recieved_byte pulse after stop mid-sample; status[0]=1; read rx_address -> data_out=0xA3 next cycle; status[0]=0.
- Send 17 frames without reading (depth 16) -> 16 stored, overrun=1; first read returns frame 1; write 0x10 to status clears overrun.
- Drive a frame with stop=0 -> no store, frame_error=1, rx_not_empty=0; a 1-clock-wide rx glitch causes no store and no flags.
- With BUFF_UART_PARITY_EN, control=0x18 (parity odd): transmit 0x01 -> parity bit 0; received 0x01 with parity 1 -> stored, parity_error=1.
